// File: rtl/window_buffer_pkg.sv
// Shared helpers for the sliding-window stream buffer: log2 sizing,
// counter widths and the flat tap index of a window element.
package window_buffer_pkg;

  localparam int unsigned COORD_Y_W = 16;

  // Ceiling log2; clog2(0) = clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Width of a counter holding 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  function automatic int unsigned col_cnt_w(input int unsigned img_width);
    return cnt_w(img_width);
  endfunction

  function automatic int unsigned row_cnt_w(input int unsigned win_rows);
    return cnt_w(win_rows);
  endfunction

  // Line storage keeps one word in the read register, so the array holds depth-1 words.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return cnt_w((depth > 1) ? depth - 1 : 1);
  endfunction

  // Flat index of tap (r,c): r=0 oldest line, c=0 oldest column.
  function automatic int unsigned tap_index(input int unsigned r, input int unsigned c,
                                            input int unsigned cols);
    return r * cols + c;
  endfunction

endpackage

// File: rtl/line_buffer_ram.sv
// Single-port read-before-write line store used as a DEPTH-word delay line.
// The array holds DEPTH-1 words and the registered read port holds the last,
// so a word written on one enabled cycle is presented on rdata right after
// the enabled cycle DEPTH-1 enables later, ready for use on the DEPTH-th.
// Ports: clk; en (access strobe); addr (ring pointer); wdata; rdata (registered).
// No reset: contents are qualified by the owner's row counter.
module line_buffer_ram
  import window_buffer_pkg::*;
#(
  parameter  int unsigned DEPTH = 20,
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned AW    = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  if (DEPTH > 1) begin : g_array
    logic [WIDTH-1:0] mem [DEPTH-1];

    // Old word is returned while the new one replaces it.
    always_ff @(posedge clk) begin
      if (en) begin
        rdata     <= mem[addr];
        mem[addr] <= wdata;
      end
    end
  end else begin : g_reg
    logic addr_unused;
    assign addr_unused = ^addr;

    // One-pixel lines: the read register alone is the delay line.
    always_ff @(posedge clk) begin
      if (en) rdata <= wdata;
    end
  end

endmodule

// File: rtl/window_stream_buffer.sv
// Sliding WIN_ROWS x WIN_COLS window generator for raster pixel streams with
// ready/valid flow control, RAM-backed line history and frame restart on in_sof.
// Ports: clk, rst_n (async, active low); in_valid/in_ready/in_data/in_sof (pixel
// input, in_ready combinational); out_valid/out_ready/out_window (window output,
// tap (r,c) at [(r*WIN_COLS+c)*BITWIDTH +: BITWIDTH], r=0 oldest line).
// Option WINDOW_COORD_EN: adds out_x/out_y, position of the newest tap.
module window_stream_buffer
  import window_buffer_pkg::*;
#(
  parameter  int unsigned BITWIDTH  = 8,
  parameter  int unsigned IMG_WIDTH = 20,
  parameter  int unsigned WIN_ROWS  = 3,
  parameter  int unsigned WIN_COLS  = 3,
  localparam int unsigned COL_W     = col_cnt_w(IMG_WIDTH),
  localparam int unsigned WIN_W     = WIN_ROWS * WIN_COLS * BITWIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITWIDTH-1:0] in_data,
  input  logic                in_sof,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIN_W-1:0]    out_window
`ifdef WINDOW_COORD_EN
  ,
  output logic [COL_W-1:0]     out_x,
  output logic [COORD_Y_W-1:0] out_y
`endif
);

  localparam int unsigned ROW_W    = row_cnt_w(WIN_ROWS);
  localparam int unsigned PTR_W    = ptr_w(IMG_WIDTH);
  localparam int unsigned LINE_W   = (WIN_ROWS - 1) * BITWIDTH;
  localparam int unsigned PTR_LAST = (IMG_WIDTH > 1) ? IMG_WIDTH - 2 : 0;

  logic                accept;
  logic [COL_W-1:0]    col_q;
  logic [COL_W-1:0]    col_c;
  logic [ROW_W-1:0]    row_q;
  logic [ROW_W-1:0]    row_c;
  logic [PTR_W-1:0]    ptr_q;
  logic                line_end_c;
  logic                complete_c;
  logic [LINE_W-1:0]   line_rd;
  logic [LINE_W-1:0]   line_wr;
  logic [BITWIDTH-1:0] new_col [WIN_ROWS];
  logic [BITWIDTH-1:0] win_q   [WIN_ROWS][WIN_COLS];

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Position of the pixel being offered; sof forces the frame origin.
  always_comb begin
    col_c      = in_sof ? '0 : col_q;
    row_c      = in_sof ? '0 : row_q;
    line_end_c = (col_c == COL_W'(IMG_WIDTH - 1));
    complete_c = (row_c == ROW_W'(WIN_ROWS - 1)) && (col_c >= COL_W'(WIN_COLS - 1));
  end

  // Incoming column = older pixels of this column plus the new pixel; the
  // write-back drops the oldest so the word always holds the last lines.
  always_comb begin
    line_wr = '0;
    for (int unsigned r = 0; r < WIN_ROWS - 1; r++) begin
      new_col[r] = line_rd[r*BITWIDTH +: BITWIDTH];
    end
    new_col[WIN_ROWS-1] = in_data;
    for (int unsigned r = 0; r < WIN_ROWS - 1; r++) begin
      line_wr[r*BITWIDTH +: BITWIDTH] = new_col[r+1];
    end
  end

  // The ring pointer is independent of col; the store is a pure IMG_WIDTH-accept delay.
  line_buffer_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (LINE_W)
  ) u_line_buffer_ram (
    .clk   (clk),
    .en    (accept),
    .addr  (ptr_q),
    .wdata (line_wr),
    .rdata (line_rd)
  );

  // Counters, window shift register and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      ptr_q     <= '0;
      out_valid <= 1'b0;
      for (int unsigned r = 0; r < WIN_ROWS; r++) begin
        for (int unsigned c = 0; c < WIN_COLS; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      col_q     <= line_end_c ? '0 : col_c + COL_W'(1);
      row_q     <= (line_end_c && (row_c != ROW_W'(WIN_ROWS - 1))) ? row_c + ROW_W'(1) : row_c;
      ptr_q     <= (ptr_q == PTR_W'(PTR_LAST)) ? '0 : ptr_q + PTR_W'(1);
      out_valid <= complete_c;
      for (int unsigned r = 0; r < WIN_ROWS; r++) begin
        for (int unsigned c = 0; c + 1 < WIN_COLS; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
        win_q[r][WIN_COLS-1] <= new_col[r];
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_comb begin
    out_window = '0;
    for (int unsigned r = 0; r < WIN_ROWS; r++) begin
      for (int unsigned c = 0; c < WIN_COLS; c++) begin
        out_window[tap_index(r, c, WIN_COLS)*BITWIDTH +: BITWIDTH] = win_q[r][c];
      end
    end
  end

`ifdef WINDOW_COORD_EN
  logic [COORD_Y_W-1:0] y_q;
  logic [COORD_Y_W-1:0] y_c;

  assign y_c = in_sof ? '0 : y_q;

  // Full-line count since sof, saturating; captured with the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= '0;
      out_x <= '0;
      out_y <= '0;
    end else if (accept) begin
      out_x <= col_c;
      out_y <= y_c;
      y_q   <= (line_end_c && (y_c != '1)) ? y_c + COORD_Y_W'(1) : y_c;
    end
  end
`endif

endmodule

// File: tb/tb_window_stream_buffer.sv
// Directed bench for window_stream_buffer (IMG_WIDTH=5, 3x3 window) with a
// scoreboard of expected windows built from a frame model; WINDOW_COORD_EN aware.
module tb_window_stream_buffer;

  localparam int unsigned BW = 8;
  localparam int unsigned IW = 5;
  localparam int unsigned WR = 3;
  localparam int unsigned WC = 3;
  localparam int unsigned WW = WR * WC * BW;

  typedef struct {
    logic [WW-1:0] win;
    int            x;
    int            y;
  } sb_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_data;
  logic          in_sof;
  logic          out_valid;
  logic          out_ready;
  logic [WW-1:0] out_window;
`ifdef WINDOW_COORD_EN
  logic [2:0]    out_x;
  logic [15:0]   out_y;
`endif

  int total = 0;
  int bad   = 0;

  // Frame model state.
  logic [BW-1:0] img [64][IW];
  int            mx = 0;
  int            my = 0;
  logic          mdl_valid = 1'b0;
  sb_t           sb [$];
  logic [WW-1:0] seen [$];

  window_stream_buffer #(
    .BITWIDTH  (BW),
    .IMG_WIDTH (IW),
    .WIN_ROWS  (WR),
    .WIN_COLS  (WC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_sof     (in_sof),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_window (out_window)
`ifdef WINDOW_COORD_EN
    ,
    .out_x      (out_x),
    .out_y      (out_y)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Window whose oldest tap is pixel 'base' of a gapless IW-wide frame.
  function automatic logic [WW-1:0] mk_win(input int base);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < int'(WR); r++)
      for (int c = 0; c < int'(WC); c++)
        w[(r*int'(WC)+c)*int'(BW) +: BW] = BW'(base + r*int'(IW) + c);
    return w;
  endfunction

  task automatic model_accept(input logic [BW-1:0] d, input logic sof);
    sb_t e;
    if (sof) begin
      mx = 0;
      my = 0;
    end
    img[my % 64][mx] = d;
    if (my >= int'(WR) - 1 && mx >= int'(WC) - 1) begin
      e.win = '0;
      for (int r = 0; r < int'(WR); r++)
        for (int c = 0; c < int'(WC); c++)
          e.win[(r*int'(WC)+c)*int'(BW) +: BW] = img[(my - int'(WR) + 1 + r) % 64][mx - int'(WC) + 1 + c];
      e.x = mx;
      e.y = (my > 65535) ? 65535 : my;
      sb.push_back(e);
      mdl_valid = 1'b1;
    end else begin
      mdl_valid = 1'b0;
    end
    mx++;
    if (mx == int'(IW)) begin
      mx = 0;
      my++;
    end
  endtask

  // One clock: drive at negedge, check outputs 1ns later, update the model.
  task automatic step(input logic v, input logic [BW-1:0] d, input logic sof,
                      input logic ordy, output logic acc);
    logic want_ready;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    in_sof    = sof;
    out_ready = ordy;
    #1;
    want_ready = !mdl_valid || ordy;
    check("in_ready", 128'(in_ready), 128'(want_ready));
    check("out_valid", 128'(out_valid), 128'(mdl_valid));
    if (mdl_valid) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL scoreboard observed=empty expected=pending window");
      end
      if (sb.size() > 0) begin
        check("out_window", 128'(out_window), 128'(sb[0].win));
`ifdef WINDOW_COORD_EN
        check("out_x", 128'(out_x), 128'(sb[0].x));
        check("out_y", 128'(out_y), 128'(sb[0].y));
`endif
        if (ordy) begin
          seen.push_back(out_window);
          void'(sb.pop_front());
        end
      end
    end
    acc = v && want_ready;
    if (acc) model_accept(d, sof);
    else if (ordy) mdl_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_window", 128'(out_window), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
`ifdef WINDOW_COORD_EN
    check("rst_out_x", 128'(out_x), 128'(0));
    check("rst_out_y", 128'(out_y), 128'(0));
`endif
    mdl_valid = 1'b0;
    mx = 0;
    my = 0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Stream pixels 0..npix-1 (value = index); optional first-window stall and input gaps.
  task automatic run_stream(input int npix, input int sof_a, input int sof_b,
                            input int stall_len, input bit gaps, input bit drain);
    int   p;
    int   stall_left;
    logic acc;
    logic v;
    logic ordy;
    p = 0;
    stall_left = stall_len;
    seen.delete();
    for (int cyc = 0; cyc < 2000 && p < npix; cyc++) begin
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      ordy = 1'b1;
      if (mdl_valid && stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end
      step(v, BW'(p), (p == sof_a) || (p == sof_b), ordy, acc);
      if (acc) p++;
    end
    check("stream_budget", 128'(p), 128'(npix));
    if (drain) repeat (4) step(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic check_seen(input string tag, input int idx, input int base);
    total++;
    assert (idx < seen.size()) else begin
      bad++;
      $error("FAIL %s observed=missing expected=window index %0d", tag, idx);
    end
    if (idx < seen.size()) check(tag, 128'(seen[idx]), 128'(mk_win(base)));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    out_ready = 1'b0;

    // Gapless frame with sof on pixel 0.
    do_reset();
    run_stream(25, 0, -1, 0, 1'b0, 1'b1);
    check("s1_count", 128'(seen.size()), 128'(9));
    check_seen("s1_first", 0, 0);
    check_seen("s1_last", 8, 12);

    // Four-cycle backpressure on the first window.
    do_reset();
    run_stream(25, 0, -1, 4, 1'b0, 1'b1);
    check("s2_count", 128'(seen.size()), 128'(9));
    check_seen("s2_first", 0, 0);
    check_seen("s2_second", 1, 1);

    // Frame restart on pixel 8.
    do_reset();
    run_stream(24, 0, 8, 0, 1'b0, 1'b1);
    check("s3_count", 128'(seen.size()), 128'(3));
    check_seen("s3_first", 0, 8);
    check_seen("s3_last", 2, 10);

    // Reset mid line 2 with a window pending, then restart without sof.
    do_reset();
    run_stream(14, 0, -1, 0, 1'b0, 1'b0);
    do_reset();
    run_stream(25, -1, -1, 0, 1'b0, 1'b1);
    check("s4_count", 128'(seen.size()), 128'(9));
    check_seen("s4_first", 0, 0);
    check_seen("s4_last", 8, 12);

    // Random input gaps with steady out_ready.
    do_reset();
    run_stream(25, 0, -1, 0, 1'b1, 1'b1);
    check("s5_count", 128'(seen.size()), 128'(9));
    check_seen("s5_first", 0, 0);
    check_seen("s5_mid", 4, 6);
    check_seen("s5_last", 8, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
